// File: rtl/vga_pkg.sv
// Shared types and default geometry for the framebuffer slice.
package vga_pkg;

    localparam int unsigned H_RES_DEF  = 640;
    localparam int unsigned V_RES_DEF  = 480;
    localparam int unsigned DATA_W_DEF = 24;
    localparam int unsigned ADDR_W     = $clog2(H_RES_DEF * V_RES_DEF);

    typedef logic [DATA_W_DEF-1:0] pixel_t;
    typedef logic [ADDR_W-1:0]     pix_addr_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        FILL
    } fb_state_t;

endpackage

// File: rtl/vga_fb_fifo.sv
// Synchronous write-buffer FIFO; an extra pointer bit tells full from empty.
module vga_fb_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic [WIDTH-1:0] store [DEPTH];

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign pop_data = store[rd_ptr[PW-1:0]];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push && !full)
            store[wr_ptr[PW-1:0]] <= push_data;
    end

endmodule

// File: rtl/vga_fb.sv
// Pixel framebuffer feeding the vga controller: buffered pixel writes,
// combinational display read and a whole-frame fill engine.
module vga_fb
    import vga_pkg::*;
#(
    parameter int unsigned H_RES      = H_RES_DEF,
    parameter int unsigned V_RES      = V_RES_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [9:0]        h_addr,
    input  logic [8:0]        v_addr,
    output logic [DATA_W-1:0] vga_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [9:0]        wr_x,
    input  logic [8:0]        wr_y,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clear,
    input  logic [DATA_W-1:0] clear_color,
    output logic              busy,
    output logic [15:0]       drop_cnt
);

    localparam int unsigned NPIX = H_RES * V_RES;
    localparam int unsigned AW   = $clog2(NPIX);
    localparam int unsigned EW   = AW + DATA_W;

    logic [DATA_W-1:0] mem [NPIX];

    fb_state_t         state;
    logic [AW-1:0]     fill_cnt;
    logic [DATA_W-1:0] fill_color;

    logic              in_range;
    logic              accept;
    logic              push;
    logic              pop;
    logic [AW-1:0]     wr_addr;
    logic              fifo_full;
    logic              fifo_empty;
    logic [EW-1:0]     fifo_out;
    logic [AW-1:0]     pop_addr;
    logic [DATA_W-1:0] pop_data;
    logic              fill_last;

    assign in_range  = (32'(wr_x) < H_RES) && (32'(wr_y) < V_RES);
    assign wr_addr   = AW'(32'(wr_y) * H_RES + 32'(wr_x));
    assign wr_ready  = !fifo_full && (state == IDLE);
    assign accept    = wr_valid && wr_ready;
    assign push      = accept && in_range;
    assign pop       = !fifo_empty && (state == IDLE || state == DRAIN);
    assign fill_last = (fill_cnt == AW'(NPIX - 1));
    assign {pop_addr, pop_data} = fifo_out;

    vga_fb_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data ({wr_addr, wr_data}),
        .pop       (pop),
        .pop_data  (fifo_out),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            fill_cnt   <= '0;
            fill_color <= '0;
            drop_cnt   <= '0;
        end else begin
            if (accept && !in_range && drop_cnt != '1)
                drop_cnt <= drop_cnt + 16'd1;
            case (state)
                IDLE: begin
                    if (clear) begin
                        state      <= DRAIN;
                        fill_color <= clear_color;
                        busy       <= 1'b1;
                    end
                end
                // Writes accepted before the clear must reach memory before the fill.
                DRAIN: begin
                    if (fifo_empty) begin
                        state    <= FILL;
                        fill_cnt <= '0;
                    end
                end
                FILL: begin
                    if (fill_last) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        fill_cnt <= '0;
                    end else begin
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (state == FILL)
            mem[fill_cnt] <= fill_color;
        else if (pop)
            mem[pop_addr] <= pop_data;
    end

    always_comb begin
        vga_data = '0;
        if (32'(h_addr) < H_RES && 32'(v_addr) < V_RES)
            vga_data = mem[AW'(32'(v_addr) * H_RES + 32'(h_addr))];
    end

endmodule
